div: RTL and testbench

//  Sequential signed fixed-point divider: io_valOut = io_a / io_b, rounded half-to-even.

---
 rtl/maths_pkg.sv | 28 ++
 rtl/div_step.sv | 29 ++
 rtl/div.sv | 181 ++++++++++++++++++
 tb/tb_div.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/maths_pkg.sv
// Shared fixed-point definitions for the fractal datapath arithmetic blocks
// (multiplier and divider).
//   FX_WIDTH / FX_FBITS : default operand width and fractional bit count
//   fx_t                : signed fixed-point value, Q(FX_WIDTH-FX_FBITS).FX_FBITS
//   div_state_t         : divider sequencer states
//   FX_MAX / FX_MIN     : saturation values for the default width
package maths_pkg;

  localparam int FX_WIDTH = 25;
  localparam int FX_FBITS = 4;

  typedef logic signed [FX_WIDTH-1:0] fx_t;

  localparam fx_t FX_MAX = {1'b0, {(FX_WIDTH-1){1'b1}}};
  localparam fx_t FX_MIN = {1'b1, {(FX_WIDTH-1){1'b0}}};

  // FINISH publishes the staged result and pulses io_done, so that the
  // result appears ITER+3 edges after the accepting edge (2 for a zero divisor).
  typedef enum logic [2:0] {
    DIV_IDLE   = 3'd0,
    DIV_CALC   = 3'd1,
    DIV_ROUND  = 3'd2,
    DIV_SIGN   = 3'd3,
    DIV_ZERO   = 3'd4,
    DIV_FINISH = 3'd5
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring long-division step (purely combinational).
//   r_in    : partial remainder, always < b_abs
//   num_bit : next numerator bit shifted into the remainder
//   b_abs   : divisor magnitude
//   r_out   : new partial remainder
//   q_bit   : quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 25
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic             num_bit,
  input  logic [WIDTH-1:0] b_abs,
  output logic [WIDTH-1:0] r_out,
  output logic             q_bit
);

  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] r_sub;

  always_comb begin
    r_sh  = {r_in, num_bit};
    q_bit = (r_sh >= {1'b0, b_abs});
    // When the subtraction is taken the true result is below b_abs, so the
    // low WIDTH bits of the modular difference are exact.
    r_sub = r_sh[WIDTH-1:0] - b_abs;
    r_out = q_bit ? r_sub : r_sh[WIDTH-1:0];
  end

endmodule

// File: rtl/div.sv
// Sequential signed fixed-point divider: io_valOut = io_a / io_b, rounded
// half-to-even, one quotient bit per clock (restoring long division).
// Ports:
//   clock, reset      : clock (posedge), asynchronous active-high reset
//   io_start          : start request, sampled only in IDLE
//   io_a, io_b        : signed dividend / divisor, registered at start
//   io_busy           : operation in progress
//   io_done           : one-cycle pulse when result/flags are updated
//   io_valid          : result valid (no overflow, no divide-by-zero)
//   io_ovf            : quotient out of range, io_valOut saturated
//   io_dbz            : divisor was zero
//   io_valOut         : signed quotient, held until the next io_done
//   dbg_state         : current sequencer state (div_state_t encoding)
// Handshake: io_start is honoured only while idle; io_busy rises on the edge
// after the accepted start and falls together with the io_done pulse. Flags
// are cleared at start; io_valOut keeps the previous result until io_done.
module div
  import maths_pkg::*;
#(
  parameter int WIDTH = FX_WIDTH,
  parameter int FBITS = FX_FBITS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_start,
  output logic             io_busy,
  output logic             io_done,
  output logic             io_valid,
  output logic             io_ovf,
  output logic             io_dbz,
  input  logic [WIDTH-1:0] io_a,
  input  logic [WIDTH-1:0] io_b,
  output logic [WIDTH-1:0] io_valOut,
  output logic [2:0]       dbg_state
);

  localparam int ITER = WIDTH + FBITS;
  localparam int CW   = $clog2(ITER);

  // Magnitude limits for positive / negative results, at quotient width.
  localparam logic [ITER:0] LIM_POS = {{(FBITS+1){1'b0}}, 1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [ITER:0] LIM_NEG = {{(FBITS+1){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t state, state_next;

  logic             sign_r;
  logic [WIDTH-1:0] b_abs_r;
  logic [ITER-1:0]  num_r;
  logic [WIDTH-1:0] rem_r;
  logic [ITER-1:0]  quo_r;
  logic [ITER:0]    qm_r;
  logic [CW-1:0]    cnt_r;

  logic [WIDTH-1:0] stage_val;
  logic             stage_valid;
  logic             stage_ovf;
  logic             stage_dbz;

  // Magnitudes are unsigned WIDTH-bit values, so the most negative operand
  // maps to 2^(WIDTH-1) rather than wrapping.
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] step_r;
  logic             step_q;
  logic [WIDTH:0]   two_r;
  logic             round_up;

  assign a_mag = io_a[WIDTH-1] ? (~io_a + 1'b1) : io_a;
  assign b_mag = io_b[WIDTH-1] ? (~io_b + 1'b1) : io_b;

  assign two_r    = {rem_r, 1'b0};
  assign round_up = (two_r > {1'b0, b_abs_r}) ||
                    ((two_r == {1'b0, b_abs_r}) && quo_r[0]);

  assign dbg_state = state;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_in    (rem_r),
    .num_bit (num_r[ITER-1]),
    .b_abs   (b_abs_r),
    .r_out   (step_r),
    .q_bit   (step_q)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= DIV_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      DIV_IDLE:   if (io_start) state_next = (io_b == '0) ? DIV_ZERO : DIV_CALC;
      DIV_CALC:   if (cnt_r == '0) state_next = DIV_ROUND;
      DIV_ROUND:  state_next = DIV_SIGN;
      DIV_SIGN:   state_next = DIV_FINISH;
      DIV_ZERO:   state_next = DIV_FINISH;
      DIV_FINISH: state_next = DIV_IDLE;
      default:    state_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sign_r      <= 1'b0;
      b_abs_r     <= '0;
      num_r       <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      qm_r        <= '0;
      cnt_r       <= '0;
      stage_val   <= '0;
      stage_valid <= 1'b0;
      stage_ovf   <= 1'b0;
      stage_dbz   <= 1'b0;
      io_busy     <= 1'b0;
      io_done     <= 1'b0;
      io_valid    <= 1'b0;
      io_ovf      <= 1'b0;
      io_dbz      <= 1'b0;
      io_valOut   <= '0;
    end else begin
      io_done <= 1'b0;
      case (state)
        DIV_IDLE: begin
          if (io_start) begin
            sign_r   <= io_a[WIDTH-1] ^ io_b[WIDTH-1];
            b_abs_r  <= b_mag;
            num_r    <= {a_mag, {FBITS{1'b0}}};
            rem_r    <= '0;
            quo_r    <= '0;
            cnt_r    <= CW'(ITER - 1);
            io_busy  <= 1'b1;
            io_valid <= 1'b0;
            io_ovf   <= 1'b0;
            io_dbz   <= 1'b0;
          end
        end
        DIV_CALC: begin
          rem_r <= step_r;
          num_r <= {num_r[ITER-2:0], 1'b0};
          quo_r <= {quo_r[ITER-2:0], step_q};
          if (cnt_r != '0) cnt_r <= cnt_r - 1'b1;
        end
        DIV_ROUND: begin
          qm_r <= round_up ? ({1'b0, quo_r} + 1'b1) : {1'b0, quo_r};
        end
        DIV_SIGN: begin
          stage_dbz <= 1'b0;
          if (qm_r > (sign_r ? LIM_NEG : LIM_POS)) begin
            stage_ovf   <= 1'b1;
            stage_valid <= 1'b0;
            stage_val   <= sign_r ? SAT_MIN : SAT_MAX;
          end else begin
            stage_ovf   <= 1'b0;
            stage_valid <= 1'b1;
            stage_val   <= sign_r ? (~qm_r[WIDTH-1:0] + 1'b1) : qm_r[WIDTH-1:0];
          end
        end
        DIV_ZERO: begin
          stage_dbz   <= 1'b1;
          stage_ovf   <= 1'b0;
          stage_valid <= 1'b0;
          stage_val   <= '0;
        end
        DIV_FINISH: begin
          io_valOut <= stage_val;
          io_valid  <= stage_valid;
          io_ovf    <= stage_ovf;
          io_dbz    <= stage_dbz;
          io_done   <= 1'b1;
          io_busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
module tb_div;
  import maths_pkg::*;

  localparam int W    = 25;
  localparam int ITER = 29;
  localparam int RW   = W + 3; // {dbz, ovf, valid, valOut}

  logic         clock;
  logic         reset;
  logic         io_start;
  logic         io_busy, io_done, io_valid, io_ovf, io_dbz;
  logic [W-1:0] io_a, io_b, io_valOut;
  logic [2:0]   dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [RW-1:0] exp_q[$];

  div dut (
    .clock     (clock),
    .reset     (reset),
    .io_start  (io_start),
    .io_busy   (io_busy),
    .io_done   (io_done),
    .io_valid  (io_valid),
    .io_ovf    (io_ovf),
    .io_dbz    (io_dbz),
    .io_a      (io_a),
    .io_b      (io_b),
    .io_valOut (io_valOut),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: exact rational division with plain integer arithmetic.
  function automatic logic [RW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, ma, mb, n, q, r, lim;
    bit neg;
    logic [W-1:0] v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) return {1'b1, 1'b0, 1'b0, {W{1'b0}}};
    neg = a[W-1] ^ b[W-1];
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    n = ma * 16;
    q = n / mb;
    r = n % mb;
    if ((2 * r > mb) || ((2 * r == mb) && (q % 2 == 1))) q = q + 1;
    lim = neg ? 64'd16777216 : 64'd16777215;
    if (q > lim) return {1'b0, 1'b1, 1'b0, (neg ? FX_MIN : FX_MAX)};
    v = W'(neg ? -q : q);
    return {1'b0, 1'b0, 1'b1, v};
  endfunction

  // Waits for io_done, counting edges after the accepting edge.
  task automatic wait_done(input bit mid_start, output int cyc, output bit seen);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 200) begin
      if (mid_start && cyc == 5) begin
        io_start = 1'b1;
        io_a = W'($urandom);
        io_b = W'($urandom_range(1, 100));
      end
      if (mid_start && cyc == 6) io_start = 1'b0;
      @(posedge clock); #1;
      cyc++;
      if (io_done) seen = 1;
    end
  endtask

  task automatic check_result(input string tag);
    logic [RW-1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_val"},   io_valOut, e[W-1:0]);
    chk({tag, "_flags"}, {io_dbz, io_ovf, io_valid}, e[RW-1:W]);
    chk({tag, "_busy"},  io_busy, 1'b0);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit mid_start, input string tag);
    int cyc;
    bit seen;
    exp_q.push_back(model(a, b));
    @(negedge clock);
    io_a = a; io_b = b; io_start = 1'b1;
    @(posedge clock); #1;
    io_start = 1'b0;
    io_a = W'($urandom);
    io_b = W'($urandom);
    chk({tag, "_busy_on"}, io_busy, 1'b1);
    wait_done(mid_start, cyc, seen);
    chk({tag, "_latency"}, cyc, (b == '0) ? 2 : ITER + 3);
    if (seen) begin
      check_result(tag);
      @(posedge clock); #1;
      chk({tag, "_done_pulse"}, io_done, 1'b0);
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  logic [W-1:0] ra, rb;
  int cyc;
  bit seen;

  initial begin
    reset = 1'b1; io_start = 1'b0; io_a = '0; io_b = '0;
    #12;
    chk("reset_outputs", {io_busy, io_done, io_valid, io_ovf, io_dbz, io_valOut}, 64'd0);
    chk("reset_state", dbg_state, 3'd0);
    @(negedge clock); reset = 1'b0;

    // directed cases
    run_op(25'd48, 25'd32, 0, "pos_pos");
    run_op(-25'sd48, 25'd32, 0, "neg_pos");
    run_op(25'd48, -25'sd32, 0, "pos_neg");
    run_op(-25'sd48, -25'sd32, 0, "neg_neg");
    run_op(25'd1, 25'd32, 0, "tie_low");
    run_op(25'd3, 25'd32, 0, "tie_odd");
    run_op(25'd5, 25'd32, 0, "tie_even");
    run_op(25'd1, 25'd48, 0, "below_half");
    run_op(25'h1000000, -25'sd16, 0, "ovf_pos");
    run_op(25'h0FFFFFF, -25'sd1, 0, "ovf_neg");
    run_op(25'h0FFFFFF, 25'd1, 0, "ovf_pos2");
    run_op(25'h1000000, 25'd16, 0, "min_exact");
    run_op(25'h1000000, 25'h1000000, 0, "min_by_min");
    run_op(25'd0, -25'sd7, 0, "zero_num");
    run_op(25'd48, 25'd0, 0, "dbz");
    run_op(25'd100, 25'd7, 1, "start_busy");

    // reset during CALC
    run_op(25'd48, 25'd32, 0, "pre_reset");
    @(negedge clock);
    io_a = 25'd80; io_b = 25'd16; io_start = 1'b1;
    @(posedge clock); #1; io_start = 1'b0;
    repeat (10) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("abort_outputs", {io_busy, io_done, io_valid, io_ovf, io_dbz, io_valOut}, 64'd0);
    chk("abort_state", dbg_state, 3'd0);
    @(negedge clock); reset = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      chk("abort_no_done", io_done, 1'b0);
    end
    run_op(25'd80, 25'd16, 0, "after_reset");

    // back-to-back with io_start held high
    exp_q.push_back(model(25'd160, 25'd32));
    exp_q.push_back(model(-25'sd33, 25'd10));
    @(negedge clock);
    io_a = 25'd160; io_b = 25'd32; io_start = 1'b1;
    @(posedge clock); #1;
    wait_done(0, cyc, seen);
    chk("b2b_first_latency", cyc, ITER + 3);
    if (seen) check_result("b2b_first");
    io_a = -25'sd33; io_b = 25'd10;
    @(posedge clock); #1;
    io_start = 1'b0;
    chk("b2b_second_accept", io_busy, 1'b1);
    wait_done(0, cyc, seen);
    chk("b2b_second_latency", cyc, ITER + 3);
    if (seen) check_result("b2b_second");
    exp_q.delete();

    // randomized
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0: rb = W'($urandom);
        1: rb = W'($signed($urandom_range(0, 128)) - 64);
        2: rb = W'($urandom_range(0, 4096));
        default: rb = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 15));
      endcase
      if ($urandom_range(0, 4) == 0) ra = 25'h1000000;
      run_op(ra, rb, ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
